// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: CPU read port, flush control, refill port and hit/miss counters.
// slave is the cache side; master is the CPU/memory environment side.
interface cache_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output cpu_ready, cpu_rdata, busy, mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_ready, cpu_rdata, busy, mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Read-only 2-way set-associative cache controller: 4 sets, 16-byte lines, one LRU bit per set,
// 4-beat line refill, saturating hit/miss counters.
module cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLookup, StMissReq, StRefill, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [1:0]  beat_q, beat_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // valid_q[set][way]; lru_q[set] names the way to evict next
  logic [3:0][1:0] valid_q, valid_d;
  logic [3:0]      lru_q, lru_d;

  logic [25:0] tag_q  [2][4];
  logic [31:0] data_q [2][4][4];
  logic [31:0] line_q [4];

  logic [25:0] tag;
  logic [1:0]  idx;
  logic [1:0]  word;
  logic        hit0, hit1, hit_any, hit_way;
  logic [31:0] hit_word;
  logic        victim;
  logic        beat_we, fill_we;
  logic        unused_byte_off;

  assign tag  = addr_q[31:6];
  assign idx  = addr_q[5:4];
  assign word = addr_q[3:2];
  assign unused_byte_off = ^addr_q[1:0];

  assign hit0     = valid_q[idx][0] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[idx][1] && (tag_q[1][idx] == tag);
  assign hit_any  = hit0 || hit1;
  assign hit_way  = hit0 ? 1'b0 : 1'b1;
  assign hit_word = data_q[hit_way][idx][word];

  // Fill invalid ways first, only then fall back to LRU
  always_comb begin
    if (!valid_q[idx][0]) begin
      victim = 1'b0;
    end else if (!valid_q[idx][1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    lru_d       = lru_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    beat_we     = 1'b0;
    fill_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          valid_d = '0;
          lru_d   = '0;
        end else if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          state_d = StLookup;
        end
      end

      StLookup: begin
        if (hit_any) begin
          cpu_rdata_d = hit_word;
          cpu_ready_d = 1'b1;
          lru_d[idx]  = ~hit_way;
          if (hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
          end
          state_d = StIdle;
        end else begin
          if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
          end
          mem_req_d  = 1'b1;
          mem_addr_d = {tag, idx, 4'b0000};
          beat_d     = 2'd0;
          state_d    = StMissReq;
        end
      end

      StMissReq: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StRefill;
        end
      end

      StRefill: begin
        if (bus.mem_rvalid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            fill_we                = 1'b1;
            valid_d[idx][victim]   = 1'b1;
            lru_d[idx]             = ~victim;
            state_d                = StResp;
          end
        end
      end

      StResp: begin
        cpu_rdata_d = line_q[word];
        cpu_ready_d = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      beat_q      <= '0;
      valid_q     <= '0;
      lru_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Storage arrays carry no reset; valid bits alone decide what is live
  always_ff @(posedge clk) begin
    if (beat_we) begin
      line_q[beat_q] <= bus.mem_rdata;
    end
    if (fill_we) begin
      tag_q[victim][idx]     <= tag;
      data_q[victim][idx][0] <= line_q[0];
      data_q[victim][idx][1] <= line_q[1];
      data_q[victim][idx][2] <= line_q[2];
      data_q[victim][idx][3] <= bus.mem_rdata;
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: table of read transactions with hand-computed results, plus
// sequences for back-to-back, flush-vs-request, and reset in the middle of a refill.
module tb_cache_ctrl;

  logic clk;
  logic rst;

  cache_ctrl_if bus_if ();

  cache_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] addr;
    int          gnt_dly;
    logic [7:0]  pat;
    logic        exp_miss;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory returns 0xA000_0000 | word address; rvalid follows pat (LSB first) after the grant.
  task automatic do_read(input logic [31:0] addr, input int gnt_dly, input logic [7:0] pat,
                         output logic [31:0] rdata, output logic missed,
                         output logic [31:0] maddr, output int lat, output int pulses,
                         output logic stable);
    int   cyc;
    int   beat;
    int   pidx;
    int   wait_c;
    logic granted;
    cyc = 0; beat = 0; pidx = 0; wait_c = 0; granted = 1'b0;
    missed = 1'b0; maddr = '0; lat = 0; pulses = 0; stable = 1'b1; rdata = '0;
    @(negedge clk);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = addr;
    @(negedge clk);
    bus_if.cpu_req  = 1'b0;
    bus_if.cpu_addr = 32'hFFFF_FFF0;
    cyc = 1;
    while (pulses == 0 && cyc < 200) begin
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = 32'hBAD0_0000 | 32'(pidx);
      if (bus_if.mem_req && !granted) begin
        if (!missed) maddr = bus_if.mem_addr;
        else if (bus_if.mem_addr !== maddr) stable = 1'b0;
        missed = 1'b1;
        // junk beats before the grant must be ignored
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 32'hDEAD_0000;
        if (wait_c == gnt_dly) begin
          bus_if.mem_gnt = 1'b1;
          granted        = 1'b1;
        end
        wait_c++;
      end else if (granted && beat < 4) begin
        bus_if.mem_rvalid = pat[pidx % 8];
        if (pat[pidx % 8]) begin
          bus_if.mem_rdata = 32'hA000_0000 | maddr | 32'(beat * 4);
          beat++;
        end
        pidx++;
      end
      @(negedge clk);
      cyc++;
      if (bus_if.cpu_ready) begin
        pulses++;
        lat   = cyc;
        rdata = bus_if.cpu_rdata;
      end
    end
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    @(negedge clk);
    if (bus_if.cpu_ready) pulses++;
  endtask

  logic [31:0] rd;
  logic        missed;
  logic [31:0] maddr;
  int          lat;
  int          pulses;
  logic        stable;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h0000_0104, 2, 8'hFF, 1'b1, 32'h0000_0100, 32'hA000_0104, 16'd0, 16'd1};
    vecs[1]  = '{32'h0000_0108, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_0108, 16'd1, 16'd1};
    vecs[2]  = '{32'h0000_020C, 0, 8'hFF, 1'b1, 32'h0000_0200, 32'hA000_020C, 16'd1, 16'd2};
    vecs[3]  = '{32'h0000_0100, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_0100, 16'd2, 16'd2};
    vecs[4]  = '{32'h0000_0304, 1, 8'hFF, 1'b1, 32'h0000_0300, 32'hA000_0304, 16'd2, 16'd3};
    vecs[5]  = '{32'h0000_010C, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_010C, 16'd3, 16'd3};
    vecs[6]  = '{32'h0000_0200, 3, 8'h59, 1'b1, 32'h0000_0200, 32'hA000_0200, 16'd3, 16'd4};
    vecs[7]  = '{32'h0000_0208, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_0208, 16'd4, 16'd4};
    vecs[8]  = '{32'h0000_0304, 0, 8'hFF, 1'b1, 32'h0000_0300, 32'hA000_0304, 16'd4, 16'd5};
    vecs[9]  = '{32'h0000_020C, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_020C, 16'd5, 16'd5};
    vecs[10] = '{32'h0000_1234, 1, 8'hFF, 1'b1, 32'h0000_1230, 32'hA000_1234, 16'd5, 16'd6};
    vecs[11] = '{32'h0000_1238, 0, 8'hFF, 1'b0, 32'h0,         32'hA000_1238, 16'd6, 16'd6};

    rst = 1'b1;
    bus_if.cpu_req    = 1'b0;
    bus_if.cpu_addr   = '0;
    bus_if.flush      = 1'b0;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", 32'(bus_if.cpu_ready), 32'd0);
    chk("rst_cpu_rdata", bus_if.cpu_rdata, 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
    chk("rst_hit_cnt", 32'(bus_if.hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(bus_if.miss_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_read(vecs[i].addr, vecs[i].gnt_dly, vecs[i].pat, rd, missed, maddr, lat, pulses, stable);
      chk($sformatf("v%0d_miss", i), 32'(missed), 32'(vecs[i].exp_miss));
      if (vecs[i].exp_miss) begin
        chk($sformatf("v%0d_mem_addr", i), maddr, vecs[i].exp_maddr);
        chk($sformatf("v%0d_mem_addr_stable", i), 32'(stable), 32'd1);
      end else begin
        chk($sformatf("v%0d_hit_latency", i), 32'(lat), 32'd2);
      end
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_ready_pulses", i), 32'(pulses), 32'd1);
      chk($sformatf("v%0d_hit_cnt", i), 32'(bus_if.hit_cnt), 32'(vecs[i].exp_hit));
      chk($sformatf("v%0d_miss_cnt", i), 32'(bus_if.miss_cnt), 32'(vecs[i].exp_miss_cnt));
    end

    // Back-to-back: second request accepted in the cycle cpu_ready is high
    @(negedge clk);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h0000_1234;
    @(negedge clk);
    bus_if.cpu_addr = 32'h0000_1238;
    @(negedge clk);
    chk("b2b_ready1", 32'(bus_if.cpu_ready), 32'd1);
    chk("b2b_rdata1", bus_if.cpu_rdata, 32'hA000_1234);
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    chk("b2b_gap_ready", 32'(bus_if.cpu_ready), 32'd0);
    chk("b2b_gap_busy", 32'(bus_if.busy), 32'd1);
    @(negedge clk);
    chk("b2b_ready2", 32'(bus_if.cpu_ready), 32'd1);
    chk("b2b_rdata2", bus_if.cpu_rdata, 32'hA000_1238);
    chk("b2b_hit_cnt", 32'(bus_if.hit_cnt), 32'd8);
    @(negedge clk);
    chk("b2b_rdata_hold", bus_if.cpu_rdata, 32'hA000_1238);

    // Flush wins over a simultaneous request
    bus_if.flush    = 1'b1;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h0000_0104;
    @(negedge clk);
    bus_if.flush   = 1'b0;
    bus_if.cpu_req = 1'b0;
    chk("flush_busy", 32'(bus_if.busy), 32'd0);
    chk("flush_hit_cnt", 32'(bus_if.hit_cnt), 32'd8);
    chk("flush_miss_cnt", 32'(bus_if.miss_cnt), 32'd6);
    do_read(32'h0000_0104, 0, 8'hFF, rd, missed, maddr, lat, pulses, stable);
    chk("postflush_miss", 32'(missed), 32'd1);
    chk("postflush_rdata", rd, 32'hA000_0104);
    chk("postflush_miss_cnt", 32'(bus_if.miss_cnt), 32'd7);

    // Reset while mem_req is pending
    @(negedge clk);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h0000_1234;
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_mem_req", 32'(bus_if.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_missreq_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_missreq_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_missreq_mem_addr", bus_if.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after two refill beats
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h0000_1234;
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h5555_0000;
    @(negedge clk);
    bus_if.mem_rdata  = 32'h5555_0001;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    chk("refill_busy", 32'(bus_if.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_refill_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_refill_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_refill_miss_cnt", 32'(bus_if.miss_cnt), 32'd0);
    chk("rst_refill_hit_cnt", 32'(bus_if.hit_cnt), 32'd0);
    chk("rst_refill_rdata", bus_if.cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_read(32'h0000_1234, 1, 8'hFF, rd, missed, maddr, lat, pulses, stable);
    chk("after_rst_miss", 32'(missed), 32'd1);
    chk("after_rst_mem_addr", maddr, 32'h0000_1230);
    chk("after_rst_rdata", rd, 32'hA000_1234);
    chk("after_rst_pulses", 32'(pulses), 32'd1);
    chk("after_rst_miss_cnt", 32'(bus_if.miss_cnt), 32'd1);
    do_read(32'h0000_1230, 0, 8'hFF, rd, missed, maddr, lat, pulses, stable);
    chk("after_rst_hit", 32'(missed), 32'd0);
    chk("after_rst_hit_rdata", rd, 32'hA000_1230);
    chk("after_rst_hit_cnt", 32'(bus_if.hit_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
